// File: rtl/scb_pkg.sv
// Shared types and helpers for the per-warp in-flight instruction scoreboard.
package scb_pkg;

  // Architectural register ID width.
  localparam int REG_W = 5;

  // Upper bound on entries per warp that lowest_free can search.
  localparam int MAX_DEPTH = 64;

  // One scoreboard entry.
  //   v   : entry holds an in-flight instruction
  //   dst : destination register
  //   dv  : dst is meaningful (instruction writes a register)
  //   rp  : replay-complete event still outstanding (LW/SW)
  //   wb  : write-back / clear already observed while rp was set
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] dst;
    logic             dv;
    logic             rp;
    logic             wb;
  } scb_entry_t;

  // Lowest index in [0, depth) whose valid bit is clear; 0 when none is free.
  function automatic int lowest_free(input logic [MAX_DEPTH-1:0] valid_vec,
                                     input int depth);
    int idx;
    idx = 0;
    for (int i = MAX_DEPTH - 1; i >= 0; i--) begin
      if (i < depth && !valid_vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/scb_warp_slice.sv
// Scoreboard storage and status for a single warp: DEPTH entries, allocation
// pointer, full/empty and dependency detection against the incoming instruction.
module scb_warp_slice
  import scb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             deposit,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic [REG_W-1:0] dst,
  input  logic             src1_valid,
  input  logic             src2_valid,
  input  logic             dst_valid,
  input  logic             replayable,
  input  logic             replay_complete,
  input  logic [ID_W-1:0]  replay_id,
  input  logic             replay_sw,
  input  logic [DEPTH-1:0] clear_hit,
  output logic             full,
  output logic             empty,
  output logic             dependent,
  output logic [ID_W-1:0]  scb_id
);

  scb_entry_t       ent     [DEPTH];
  scb_entry_t       ent_nxt [DEPTH];
  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH-1:0] clr_now;
  logic [DEPTH-1:0] rc_now;
  logic [DEPTH-1:0] free_now;
  logic             do_deposit;

  // Status and hazard detection from the pre-update entry state; no bypass of
  // same-cycle clears.
  always_comb begin
    valid_vec = '0;
    dependent = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      valid_vec[e] = ent[e].v;
      if (ent[e].v && ent[e].dv) begin
        if (src1_valid && ent[e].dst == src1) dependent = 1'b1;
        if (src2_valid && ent[e].dst == src2) dependent = 1'b1;
        if (dst_valid  && ent[e].dst == dst)  dependent = 1'b1;
      end
      // Memory ordering: a new LW/SW waits behind any older pending replay.
      if (ent[e].v && ent[e].rp && replayable) dependent = 1'b1;
    end
  end

  assign full       = &valid_vec;
  assign empty      = ~|valid_vec;
  assign scb_id     = full ? '0 : ID_W'(lowest_free(MAX_DEPTH'(valid_vec), DEPTH));
  assign do_deposit = deposit && !full;

  // Next-state for every entry: clear, replay completion, then allocation.
  always_comb begin
    clr_now  = '0;
    rc_now   = '0;
    free_now = '0;
    for (int e = 0; e < DEPTH; e++) begin
      ent_nxt[e] = ent[e];
      clr_now[e] = clear_hit[e] && ent[e].v;
      rc_now[e]  = replay_complete && (replay_id == ID_W'(e)) && ent[e].v;

      // A clear on an entry still waiting for its replay only records the
      // write-back; the entry stays allocated until the replay completes.
      if (clr_now[e]) begin
        if (ent[e].rp) ent_nxt[e].wb = 1'b1;
        else           free_now[e]   = 1'b1;
      end

      // Stores have no write-back, so completion alone frees them. Loads free
      // once both the replay and the write-back (possibly this cycle) are seen.
      if (rc_now[e]) begin
        if (replay_sw) begin
          free_now[e] = 1'b1;
        end else begin
          ent_nxt[e].rp = 1'b0;
          if (ent[e].wb || clr_now[e]) free_now[e] = 1'b1;
        end
      end

      if (free_now[e]) ent_nxt[e] = '0;

      // The allocation slot was already free, so it never collides with the
      // clear/replay updates above.
      if (do_deposit && scb_id == ID_W'(e)) begin
        ent_nxt[e].v   = 1'b1;
        ent_nxt[e].dst = dst;
        ent_nxt[e].dv  = dst_valid;
        ent_nxt[e].rp  = replayable;
        ent_nxt[e].wb  = 1'b0;
      end
    end
  end

  // Entry registers with synchronous reset.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (rst) ent[e] <= '0;
      else     ent[e] <= ent_nxt[e];
    end
  end

endmodule

// File: rtl/scoreboard_nport.sv
// Parametrised multi-warp scoreboard: tracks in-flight register-writing and
// memory instructions between the IBuffer and the ALU/CDB/MEM clear paths.
module scoreboard_nport
  import scb_pkg::*;
#(
  parameter int NUM_WARPS    = 8,
  parameter int DEPTH        = 4,
  parameter int NUM_CLR      = 2,
  parameter int ID_W         = $clog2(DEPTH),
  parameter int LOGNUM_WARPS = $clog2(NUM_WARPS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_WARPS-1:0]            RP_Grt_IB_Scb,
  input  logic [REG_W*NUM_WARPS-1:0]      Src1_Flattened_IB_Scb,
  input  logic [REG_W*NUM_WARPS-1:0]      Src2_Flattened_IB_Scb,
  input  logic [REG_W*NUM_WARPS-1:0]      Dst_Flattened_IB_Scb,
  input  logic [NUM_WARPS-1:0]            Src1_Valid_IB_Scb,
  input  logic [NUM_WARPS-1:0]            Src2_Valid_IB_Scb,
  input  logic [NUM_WARPS-1:0]            Dst_Valid_IB_Scb,
  input  logic [NUM_WARPS-1:0]            Replayable_IB_Scb,
  input  logic [NUM_WARPS-1:0]            Replay_Complete_IB_Scb,
  input  logic [ID_W*NUM_WARPS-1:0]       Replay_Complete_ScbID_Flattened_IB_Scb,
  input  logic [NUM_WARPS-1:0]            Replay_Complete_SW_LWbar_IB_Scb,
  input  logic [NUM_CLR-1:0]              Clear_Valid_Scb,
  input  logic [LOGNUM_WARPS*NUM_CLR-1:0] Clear_WarpID_Flattened_Scb,
  input  logic [ID_W*NUM_CLR-1:0]         Clear_ScbID_Flattened_Scb,
  output logic [NUM_WARPS-1:0]            Full_Scb_IB,
  output logic [NUM_WARPS-1:0]            Empty_Scb_IB,
  output logic [NUM_WARPS-1:0]            Dependent_Scb_IB,
  output logic [ID_W*NUM_WARPS-1:0]       ScbID_Flattened_Scb_IB
);

  logic [DEPTH-1:0] clear_hit [NUM_WARPS];

  // Fold all clear ports into one per-entry hit mask per warp; several ports
  // naming the same entry collapse into a single clear.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      clear_hit[w] = '0;
      for (int p = 0; p < NUM_CLR; p++) begin
        if (Clear_Valid_Scb[p] &&
            Clear_WarpID_Flattened_Scb[p*LOGNUM_WARPS +: LOGNUM_WARPS] == LOGNUM_WARPS'(w)) begin
          clear_hit[w][Clear_ScbID_Flattened_Scb[p*ID_W +: ID_W]] = 1'b1;
        end
      end
    end
  end

  // One storage slice per warp.
  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    scb_warp_slice #(
      .DEPTH (DEPTH),
      .ID_W  (ID_W)
    ) u_slice (
      .clk             (clk),
      .rst             (rst),
      .deposit         (RP_Grt_IB_Scb[w]),
      .src1            (Src1_Flattened_IB_Scb[w*REG_W +: REG_W]),
      .src2            (Src2_Flattened_IB_Scb[w*REG_W +: REG_W]),
      .dst             (Dst_Flattened_IB_Scb[w*REG_W +: REG_W]),
      .src1_valid      (Src1_Valid_IB_Scb[w]),
      .src2_valid      (Src2_Valid_IB_Scb[w]),
      .dst_valid       (Dst_Valid_IB_Scb[w]),
      .replayable      (Replayable_IB_Scb[w]),
      .replay_complete (Replay_Complete_IB_Scb[w]),
      .replay_id       (Replay_Complete_ScbID_Flattened_IB_Scb[w*ID_W +: ID_W]),
      .replay_sw       (Replay_Complete_SW_LWbar_IB_Scb[w]),
      .clear_hit       (clear_hit[w]),
      .full            (Full_Scb_IB[w]),
      .empty           (Empty_Scb_IB[w]),
      .dependent       (Dependent_Scb_IB[w]),
      .scb_id          (ScbID_Flattened_Scb_IB[w*ID_W +: ID_W])
    );
  end

endmodule

// File: tb/tb_scoreboard_nport.sv
// Self-checking bench: reference model + expected-status queue for the default
// build, directed checks for a DEPTH=8 / 3-clear-port build.
module tb_scoreboard_nport;

  localparam int NW = 8;
  localparam int DP = 4;
  localparam int NC = 2;
  localparam int IW = 2;
  localparam int LW = 3;

  localparam int BDP = 8;
  localparam int BNC = 3;
  localparam int BIW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // default build
  logic [NW-1:0]    grt, s1v, s2v, dv, repl, rc, rc_sw;
  logic [5*NW-1:0]  s1_f, s2_f, d_f;
  logic [IW*NW-1:0] rc_id_f;
  logic [NC-1:0]    clr_v;
  logic [LW*NC-1:0] clr_w_f;
  logic [IW*NC-1:0] clr_id_f;
  logic [NW-1:0]    full, empty, dep;
  logic [IW*NW-1:0] scb_id;

  // DEPTH=8, NUM_CLR=3 build
  logic [NW-1:0]     b_grt, b_s1v, b_s2v, b_dv, b_repl, b_rc, b_rc_sw;
  logic [5*NW-1:0]   b_s1_f, b_s2_f, b_d_f;
  logic [BIW*NW-1:0] b_rc_id_f;
  logic [BNC-1:0]    b_clr_v;
  logic [LW*BNC-1:0] b_clr_w_f;
  logic [BIW*BNC-1:0] b_clr_id_f;
  logic [NW-1:0]     b_full, b_empty, b_dep;
  logic [BIW*NW-1:0] b_scb_id;

  scoreboard_nport dut (
    .clk(clk), .rst(rst),
    .RP_Grt_IB_Scb(grt),
    .Src1_Flattened_IB_Scb(s1_f), .Src2_Flattened_IB_Scb(s2_f), .Dst_Flattened_IB_Scb(d_f),
    .Src1_Valid_IB_Scb(s1v), .Src2_Valid_IB_Scb(s2v), .Dst_Valid_IB_Scb(dv),
    .Replayable_IB_Scb(repl), .Replay_Complete_IB_Scb(rc),
    .Replay_Complete_ScbID_Flattened_IB_Scb(rc_id_f),
    .Replay_Complete_SW_LWbar_IB_Scb(rc_sw),
    .Clear_Valid_Scb(clr_v), .Clear_WarpID_Flattened_Scb(clr_w_f),
    .Clear_ScbID_Flattened_Scb(clr_id_f),
    .Full_Scb_IB(full), .Empty_Scb_IB(empty), .Dependent_Scb_IB(dep),
    .ScbID_Flattened_Scb_IB(scb_id)
  );

  scoreboard_nport #(.NUM_WARPS(NW), .DEPTH(BDP), .NUM_CLR(BNC)) dut_b (
    .clk(clk), .rst(rst),
    .RP_Grt_IB_Scb(b_grt),
    .Src1_Flattened_IB_Scb(b_s1_f), .Src2_Flattened_IB_Scb(b_s2_f), .Dst_Flattened_IB_Scb(b_d_f),
    .Src1_Valid_IB_Scb(b_s1v), .Src2_Valid_IB_Scb(b_s2v), .Dst_Valid_IB_Scb(b_dv),
    .Replayable_IB_Scb(b_repl), .Replay_Complete_IB_Scb(b_rc),
    .Replay_Complete_ScbID_Flattened_IB_Scb(b_rc_id_f),
    .Replay_Complete_SW_LWbar_IB_Scb(b_rc_sw),
    .Clear_Valid_Scb(b_clr_v), .Clear_WarpID_Flattened_Scb(b_clr_w_f),
    .Clear_ScbID_Flattened_Scb(b_clr_id_f),
    .Full_Scb_IB(b_full), .Empty_Scb_IB(b_empty), .Dependent_Scb_IB(b_dep),
    .ScbID_Flattened_Scb_IB(b_scb_id)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model (default build) ----------------
  logic       mv   [NW][DP];
  logic [4:0] mdst [NW][DP];
  logic       mdv  [NW][DP];
  logic       mrp  [NW][DP];
  logic       mwb  [NW][DP];
  bit         started = 1'b0;

  function automatic logic m_full(int w);
    logic r = 1'b1;
    for (int e = 0; e < DP; e++) if (!mv[w][e]) r = 1'b0;
    return r;
  endfunction

  function automatic logic m_empty(int w);
    logic r = 1'b1;
    for (int e = 0; e < DP; e++) if (mv[w][e]) r = 1'b0;
    return r;
  endfunction

  function automatic logic [IW-1:0] m_id(int w);
    logic [IW-1:0] r = '0;
    for (int e = DP - 1; e >= 0; e--) if (!mv[w][e]) r = IW'(e);
    return r;
  endfunction

  function automatic logic m_dep(int w);
    logic r = 1'b0;
    for (int e = 0; e < DP; e++) begin
      if (mv[w][e]) begin
        if (mdv[w][e] && s1v[w] && mdst[w][e] == s1_f[w*5 +: 5]) r = 1'b1;
        if (mdv[w][e] && s2v[w] && mdst[w][e] == s2_f[w*5 +: 5]) r = 1'b1;
        if (mdv[w][e] && dv[w]  && mdst[w][e] == d_f[w*5 +: 5])  r = 1'b1;
        if (mrp[w][e] && repl[w]) r = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_upd();
    logic          was_full;
    logic [IW-1:0] slot;
    logic          hit, rch, rel;
    for (int w = 0; w < NW; w++) begin
      was_full = m_full(w);
      slot     = m_id(w);
      for (int e = 0; e < DP; e++) begin
        if (rst) begin
          mv[w][e] = 1'b0; mdst[w][e] = '0; mdv[w][e] = 1'b0; mrp[w][e] = 1'b0; mwb[w][e] = 1'b0;
        end else if (mv[w][e]) begin
          hit = 1'b0;
          for (int p = 0; p < NC; p++)
            if (clr_v[p] && int'(clr_w_f[p*LW +: LW]) == w && int'(clr_id_f[p*IW +: IW]) == e)
              hit = 1'b1;
          rch = rc[w] && int'(rc_id_f[w*IW +: IW]) == e;
          rel = 1'b0;
          if (hit && !mrp[w][e]) rel = 1'b1;
          if (rch && rc_sw[w]) rel = 1'b1;
          if (rch && !rc_sw[w] && (mwb[w][e] || hit)) rel = 1'b1;
          if (hit && mrp[w][e]) mwb[w][e] = 1'b1;
          if (rch) mrp[w][e] = 1'b0;
          if (rel) begin
            mv[w][e] = 1'b0; mdst[w][e] = '0; mdv[w][e] = 1'b0; mrp[w][e] = 1'b0; mwb[w][e] = 1'b0;
          end
        end
      end
      if (!rst && grt[w] && !was_full) begin
        mv[w][slot]   = 1'b1;
        mdst[w][slot] = d_f[w*5 +: 5];
        mdv[w][slot]  = dv[w];
        mrp[w][slot]  = repl[w];
        mwb[w][slot]  = 1'b0;
      end
    end
  endtask

  // ---------------- expected-status scoreboard ----------------
  typedef struct {
    logic [NW-1:0]    full;
    logic [NW-1:0]    empty;
    logic [NW-1:0]    dep;
    logic [IW*NW-1:0] id;
  } exp_t;
  exp_t exp_q[$];

  task automatic sb_push();
    exp_t x;
    for (int w = 0; w < NW; w++) begin
      x.full[w]          = m_full(w);
      x.empty[w]         = m_empty(w);
      x.dep[w]           = m_dep(w);
      x.id[w*IW +: IW]   = m_id(w);
    end
    exp_q.push_back(x);
  endtask

  task automatic sb_pop_check();
    exp_t x;
    x = exp_q.pop_front();
    chk("sb_full",  32'(full),   32'(x.full));
    chk("sb_empty", 32'(empty),  32'(x.empty));
    chk("sb_dep",   32'(dep),    32'(x.dep));
    chk("sb_scbid", 32'(scb_id), 32'(x.id));
  endtask

  // One clock: expected status for the driven inputs is queued, the DUT
  // status is compared, the model advances, and one-cycle strobes drop.
  task automatic tick();
    #1;
    if (started) begin
      sb_push();
      sb_pop_check();
    end
    model_upd();
    if (rst) started = 1'b1;
    @(posedge clk);
    #1;
    grt = '0; rc = '0; clr_v = '0;
    b_grt = '0; b_rc = '0; b_clr_v = '0;
  endtask

  task automatic set_op(int w, int s1, bit s1val, int s2, bit s2val, int d, bit dval, bit rp);
    s1_f[w*5 +: 5] = 5'(s1); s1v[w] = s1val;
    s2_f[w*5 +: 5] = 5'(s2); s2v[w] = s2val;
    d_f[w*5 +: 5]  = 5'(d);  dv[w]  = dval;
    repl[w] = rp;
  endtask

  task automatic deposit(int w, int d, bit dval, bit rp);
    set_op(w, 0, 1'b0, 0, 1'b0, d, dval, rp);
    grt[w] = 1'b1;
    tick();
    set_op(w, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic set_clear(int p, int w, int id);
    clr_v[p] = 1'b1;
    clr_w_f[p*LW +: LW]  = LW'(w);
    clr_id_f[p*IW +: IW] = IW'(id);
  endtask

  task automatic set_replay(int w, int id, bit sw);
    rc[w] = 1'b1;
    rc_id_f[w*IW +: IW] = IW'(id);
    rc_sw[w] = sw;
  endtask

  task automatic set_bclear(int p, int w, int id);
    b_clr_v[p] = 1'b1;
    b_clr_w_f[p*LW +: LW]    = LW'(w);
    b_clr_id_f[p*BIW +: BIW] = BIW'(id);
  endtask

  initial begin
    rst = 1'b1;
    grt = '0; s1v = '0; s2v = '0; dv = '0; repl = '0; rc = '0; rc_sw = '0;
    s1_f = '0; s2_f = '0; d_f = '0; rc_id_f = '0;
    clr_v = '0; clr_w_f = '0; clr_id_f = '0;
    b_grt = '0; b_s1v = '0; b_s2v = '0; b_dv = '0; b_repl = '0; b_rc = '0; b_rc_sw = '0;
    b_s1_f = '0; b_s2_f = '0; b_d_f = '0; b_rc_id_f = '0;
    b_clr_v = '0; b_clr_w_f = '0; b_clr_id_f = '0;

    // Reset, then idle.
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_empty", 32'(empty),  32'hFF);
    chk("rst_full",  32'(full),   32'h0);
    chk("rst_dep",   32'(dep),    32'h0);
    chk("rst_scbid", 32'(scb_id), 32'h0);
    chk("rst_b_empty", 32'(b_empty), 32'hFF);
    tick();

    // Warp 3 fills up; ScbID steps 0..3, then Full with ScbID 0.
    for (int k = 0; k < DP; k++) begin
      #1 chk("w3_scbid_step", 32'(scb_id[3*IW +: IW]), 32'(k));
      deposit(3, 5 + k, 1'b1, 1'b0);
    end
    #1;
    chk("w3_full",      32'(full[3]),              32'h1);
    chk("w3_full_id",   32'(scb_id[3*IW +: IW]),   32'h0);
    deposit(3, 9, 1'b1, 1'b0);
    set_op(3, 9, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
    #1 chk("w3_drop_r9", 32'(dep[3]), 32'h0);
    set_op(3, 8, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
    #1 chk("w3_raw_src1", 32'(dep[3]), 32'h1);
    set_op(3, 5, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    #1 chk("w3_src1_invalid", 32'(dep[3]), 32'h0);
    set_op(3, 0, 1'b0, 6, 1'b1, 0, 1'b0, 1'b0);
    #1 chk("w3_raw_src2", 32'(dep[3]), 32'h1);
    set_op(3, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b0);
    #1 chk("w3_waw", 32'(dep[3]), 32'h1);
    tick();
    set_op(3, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

    // Warp 0: R7 in entry 2, cleared on port 1; no same-cycle bypass.
    deposit(0, 1, 1'b1, 1'b0);
    deposit(0, 2, 1'b1, 1'b0);
    deposit(0, 7, 1'b1, 1'b0);
    set_op(0, 7, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
    set_clear(1, 0, 2);
    #1 chk("w0_dep_no_bypass", 32'(dep[0]), 32'h1);
    tick();
    #1;
    chk("w0_dep_after_clr", 32'(dep[0]),             32'h0);
    chk("w0_scbid_freed",   32'(scb_id[0*IW +: IW]), 32'h2);
    set_op(0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

    // Warp 1: replayable LW, CDB clear first, then replay completion frees.
    deposit(1, 4, 1'b1, 1'b1);
    set_clear(1, 1, 0);
    tick();
    #1 chk("w1_lw_held", 32'(empty[1]), 32'h0);
    set_op(1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    #1 chk("w1_mem_order", 32'(dep[1]), 32'h1);
    set_replay(1, 0, 1'b0);
    tick();
    #1;
    chk("w1_lw_freed",  32'(empty[1]), 32'h1);
    chk("w1_order_off", 32'(dep[1]),   32'h0);
    set_op(1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

    // Warp 2: replayable SW freed by store completion; clear on invalid entry.
    deposit(2, 0, 1'b0, 1'b1);
    #1 chk("w2_sw_held", 32'(empty[2]), 32'h0);
    set_replay(2, 0, 1'b1);
    tick();
    #1 chk("w2_sw_freed", 32'(empty[2]), 32'h1);
    set_clear(0, 2, 3);
    tick();
    #1 chk("w2_clr_invalid", 32'(empty[2]), 32'h1);

    // LW replay before its clear: entry stays, no longer replay-pending.
    deposit(2, 10, 1'b1, 1'b1);
    set_replay(2, 0, 1'b0);
    tick();
    #1 chk("w2_lw_rc_first", 32'(empty[2]), 32'h0);
    set_op(2, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    #1 chk("w2_rp_cleared", 32'(dep[2]), 32'h0);
    set_op(2, 10, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
    #1 chk("w2_raw_r10", 32'(dep[2]), 32'h1);
    set_op(2, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    set_clear(0, 2, 0);
    tick();
    #1 chk("w2_lw_clr_frees", 32'(empty[2]), 32'h1);

    // Clear and load completion in the same cycle free the entry.
    deposit(2, 11, 1'b1, 1'b1);
    set_clear(0, 2, 0);
    set_replay(2, 0, 1'b0);
    tick();
    #1 chk("w2_clr_rc_same", 32'(empty[2]), 32'h1);

    // Warp 0 holds ids 0,1: free id 0 while depositing -> lands in id 2.
    set_clear(0, 0, 0);
    deposit(0, 12, 1'b1, 1'b0);
    #1 chk("w0_same_cycle_id", 32'(scb_id[0*IW +: IW]), 32'h0);
    deposit(0, 13, 1'b1, 1'b0);
    #1 chk("w0_next_id", 32'(scb_id[0*IW +: IW]), 32'h3);

    // Reset mid-operation discards everything.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_empty", 32'(empty), 32'hFF);
    chk("midrst_full",  32'(full),  32'h0);

    // DEPTH=8 / 3-port build: multi-port clear with a duplicate, plus deposit.
    b_grt = 8'b0000_0111; tick();
    b_grt = 8'b0000_0001; tick();
    b_grt = 8'b0000_0001; tick();
    #1 chk("b_w0_id_pre", 32'(b_scb_id[0*BIW +: BIW]), 32'h3);
    set_bclear(0, 0, 1);
    set_bclear(1, 1, 0);
    set_bclear(2, 0, 1);
    b_grt = 8'b0000_0001;
    tick();
    #1;
    chk("b_w0_id_post", 32'(b_scb_id[0*BIW +: BIW]), 32'h1);
    chk("b_w1_freed",   32'(b_empty[1]),             32'h1);
    chk("b_w2_kept",    32'(b_empty[2]),             32'h0);
    chk("b_w2_id",      32'(b_scb_id[2*BIW +: BIW]), 32'h1);
    chk("b_w0_notfull", 32'(b_full[0]),              32'h0);
    b_grt = 8'b0000_0001; tick();
    #1 chk("b_w0_refill_id", 32'(b_scb_id[0*BIW +: BIW]), 32'h4);

    // Random traffic on the default build against the model.
    for (int c = 0; c < 400; c++) begin
      for (int w = 0; w < NW; w++) begin
        set_op(w, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
               $urandom_range(0, 7), 1'($urandom_range(0, 1)),
               $urandom_range(0, 7), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) == 0));
        grt[w] = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 5) == 0) set_replay(w, $urandom_range(0, DP - 1), 1'($urandom_range(0, 1)));
      end
      for (int p = 0; p < NC; p++)
        if ($urandom_range(0, 1) == 1) set_clear(p, $urandom_range(0, NW - 1), $urandom_range(0, DP - 1));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/scoreboard_nport.md
Name: scoreboard_nport

Overview:
- Parametrised successor to the fixed 8-warp, 4-entry, 2-clear-port scoreboard.
- Tracks in-flight register-writing and memory instructions per warp, between the IBuffer (deposit, replay complete) and the ALU/CDB/MEM clear paths.
- Adds configurable warp count, entries per warp and clear-port count.
- Adds memory-ordering interlock: a replayable instruction waits while an older replay is pending in the same warp.

Parameters:
- NUM_WARPS, 8, number of hardware warps.
- DEPTH, 4, scoreboard entries per warp; must be a power of two, at least 2.
- NUM_CLR, 2, number of independent clear ports (port 0 ALU, port 1 CDB, further ports spare).
- ID_W, $clog2(DEPTH), ScbID width.
- LOGNUM_WARPS, $clog2(NUM_WARPS), warp ID width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- RP_Grt_IB_Scb  in  NUM_WARPS  deposit strobe per warp.
- Src1_Flattened_IB_Scb, Src2_Flattened_IB_Scb, Dst_Flattened_IB_Scb  in  5*NUM_WARPS each  register IDs per warp.
- Src1_Valid_IB_Scb, Src2_Valid_IB_Scb, Dst_Valid_IB_Scb  in  NUM_WARPS each  operand-used flags.
- Replayable_IB_Scb  in  NUM_WARPS  instruction is LW/SW and needs a replay-complete event.
- Replay_Complete_IB_Scb  in  NUM_WARPS  replay finished.
- Replay_Complete_ScbID_Flattened_IB_Scb  in  ID_W*NUM_WARPS  entry the replay refers to.
- Replay_Complete_SW_LWbar_IB_Scb  in  NUM_WARPS  1 = store, 0 = load.
- Clear_Valid_Scb  in  NUM_CLR  clear strobes.
- Clear_WarpID_Flattened_Scb  in  LOGNUM_WARPS*NUM_CLR  warp per clear port.
- Clear_ScbID_Flattened_Scb  in  ID_W*NUM_CLR  entry per clear port.
- Full_Scb_IB, Empty_Scb_IB, Dependent_Scb_IB  out  NUM_WARPS each  per-warp status.
- ScbID_Flattened_Scb_IB  out  ID_W*NUM_WARPS  entry the next deposit will occupy.

Behaviour:
- Entry state per warp and entry, all registered:
  - V: entry valid.
  - DST[4:0], DV: destination register and its valid flag.
  - RP: replay pending.
  - WB: write-back/clear already seen.
- Reset: every V, DV, RP, WB = 0 and DST = 0.
- Outputs are combinational from registered state plus current inputs. After reset: Full = 0, Empty = all 1s, Dependent = 0, ScbID = 0.
- ScbID[w]: lowest-index entry with V = 0. When the warp is full, ScbID = 0 and must be ignored.
- Full[w]: all DEPTH entries have V = 1. Empty[w]: no entry has V = 1.
- Dependent[w] is 1 if any valid entry e has DV = 1 and DST equal to one of:
  - Src1 with Src1_Valid = 1 (RAW),
  - Src2 with Src2_Valid = 1 (RAW),
  - Dst with Dst_Valid = 1 (WAW).
- Dependent[w] is also 1 when Replayable[w] = 1 and any valid entry has RP = 1 (memory ordering).
- Dependent is evaluated on pre-update state. A same-cycle clear does not remove a dependency until the next cycle; there is no bypass.
- Deposit, when RP_Grt[w] = 1 and Full[w] = 0:
  - Entry ScbID[w] loads V = 1, DST = Dst, DV = Dst_Valid, RP = Replayable, WB = 0.
  - The entry is visible in status at N+1.
  - A deposit while Full is dropped, with no state change; asserting it is a verification error.
- Clear, port p, when Clear_Valid[p] = 1 and the entry has V = 1:
  - If RP = 0, the entry is freed (V = 0, DV = 0).
  - If RP = 1, WB is set to 1.
  - A clear to an entry with V = 0 is ignored.
  - Several ports hitting the same entry in one cycle act as one clear.
- Replay complete, when Replay_Complete[w] = 1 and the entry has V = 1:
  - SW_LWbar = 1: the entry is freed (a store carries no write-back).
  - SW_LWbar = 0: RP is set to 0; if WB = 1 (or a clear arrives the same cycle), the entry is freed.
- Same-cycle deposit and clear/free in one warp: the deposit goes to the pre-update ScbID, which was free already, so there is no conflict. A freed entry becomes allocatable at N+1.
- Reset asserted mid-operation discards all in-flight entries at that edge.

Decomposition:
- Shared package scb_pkg holds:
  - REG_W = 5,
  - the entry record typedef (V, DST, DV, RP, WB),
  - a function that finds the lowest free index.
- One natural sub-module, scb_warp_slice:
  - holds the DEPTH entries for one warp,
  - is instantiated NUM_WARPS times with a generate loop,
  - receives per-warp clear hits already decoded from all NUM_CLR ports at the top level.

Test Plan:
- Reset, then idle → Empty = 8'hFF, Full = 0, ScbID = 0 for all warps, Dependent = 0.
- Warp 3 deposits Dst = R5 (DV = 1), four times with distinct Dst → ScbID steps 0, 1, 2, 3; after the 4th, Full[3] = 1 and ScbID = 0; a 5th deposit leaves state unchanged.
- Warp 0 holds R7 in entry 2; query Src1 = R7 → Dependent[0] = 1. Clear port 1 on (warp 0, id 2) at cycle N → Dependent[0] = 0 at N+1 and ScbID[0] = 2.
- Warp 1 deposits a replayable LW to R4 (id 0). CDB clear first → entry stays, Dependent for a new replayable instruction = 1. Replay_Complete with SW_LWbar = 0 → entry freed next cycle.
- Replayable SW (DV = 0) in warp 2 → Replay_Complete with SW_LWbar = 1 frees it. Clear on an invalid entry → no change.
- NUM_CLR = 3, DEPTH = 8 build: three ports clear distinct warps and one duplicate entry in the same cycle → all targets freed, others untouched. A deposit to the same warp that cycle lands in the pre-update lowest free entry.
